id_ex_pipe_stage: RTL and testbench

- Parametrised, elastic ID→EX pipeline register with a valid/ready handshake, stall (backpressure), synchronous flush and NOP-bubble insertion.
- Sits between the decode/register-read stage and the ALU/EX stage.
- Payload is Reg_Write, ALU_OP, two operands and the destination register index.
- Adds a saturating bubble counter for performance monitoring.

---
 rtl/id_ex_pkg.sv | 26 ++
 rtl/id_ex_pipe_stage_if.sv | 36 +++
 rtl/id_ex_skid_buf.sv | 47 ++++
 rtl/id_ex_pipe_stage.sv | 118 +++++++++++
 tb/tb_id_ex_pipe_stage.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/id_ex_pkg.sv
// Shared widths, payload type and NOP constant for the ID->EX pipeline register.
package id_ex_pkg;

    localparam int unsigned ID_EX_DATA_W   = 8;
    localparam int unsigned ID_EX_RD_W     = 3;
    localparam int unsigned ID_EX_ALU_OP_W = 1;
    localparam int unsigned ID_EX_CNT_W    = 16;

    typedef struct packed {
        logic                      reg_write;
        logic [ID_EX_ALU_OP_W-1:0] alu_op;
        logic [ID_EX_DATA_W-1:0]   data1;
        logic [ID_EX_DATA_W-1:0]   data2;
        logic [ID_EX_RD_W-1:0]     rd;
    } id_ex_payload_t;

    // A bubble: control fields cleared so EX performs no architectural update.
    localparam id_ex_payload_t ID_EX_NOP = '{
        reg_write: 1'b0,
        alu_op:    '0,
        data1:     '0,
        data2:     '0,
        rd:        '0
    };

endpackage

// File: rtl/id_ex_pipe_stage_if.sv
// ID->EX handshake and payload bundle; master = ID/EX environment, slave = pipeline stage.
interface id_ex_pipe_stage_if
    import id_ex_pkg::*;
#(
    parameter int unsigned DATA_W   = ID_EX_DATA_W,
    parameter int unsigned RD_W     = ID_EX_RD_W,
    parameter int unsigned ALU_OP_W = ID_EX_ALU_OP_W
);
    logic                in_valid;
    logic                in_ready;
    logic                Reg_Write;
    logic [ALU_OP_W-1:0] ALU_OP;
    logic [DATA_W-1:0]   Data1;
    logic [DATA_W-1:0]   Data2;
    logic [RD_W-1:0]     RD;
    logic                out_valid;
    logic                out_ready;
    logic                ID_EX_Reg_Write;
    logic [ALU_OP_W-1:0] ID_EX_ALU_OP;
    logic [DATA_W-1:0]   ID_EX_Data1;
    logic [DATA_W-1:0]   ID_EX_Data2;
    logic [RD_W-1:0]     ID_EX_RD;

    modport master (
        output in_valid, Reg_Write, ALU_OP, Data1, Data2, RD, out_ready,
        input  in_ready, out_valid, ID_EX_Reg_Write, ID_EX_ALU_OP,
               ID_EX_Data1, ID_EX_Data2, ID_EX_RD
    );

    modport slave (
        input  in_valid, Reg_Write, ALU_OP, Data1, Data2, RD, out_ready,
        output in_ready, out_valid, ID_EX_Reg_Write, ID_EX_ALU_OP,
               ID_EX_Data1, ID_EX_Data2, ID_EX_RD
    );

endinterface

// File: rtl/id_ex_skid_buf.sv
// Single-entry skid register: captures one payload while the main stage is stalled.
module id_ex_skid_buf
    import id_ex_pkg::*;
#(
    parameter type payload_t = id_ex_payload_t
) (
    input  logic     Clk,
    input  logic     Reset,
    input  logic     flush,
    input  logic     load_i,
    input  logic     pop_i,
    input  payload_t data_i,
    output logic     valid_o,
    output payload_t data_o
);

    logic     valid_q, valid_d;
    payload_t data_q, data_d;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Flush wins; load and pop never coincide because in_ready is low while full.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/id_ex_pipe_stage.sv
// Elastic ID->EX pipeline register with stall, flush, NOP bubbles and a saturating bubble counter.
// Define ID_EX_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module id_ex_pipe_stage
    import id_ex_pkg::*;
#(
    parameter int unsigned DATA_W   = ID_EX_DATA_W,
    parameter int unsigned RD_W     = ID_EX_RD_W,
    parameter int unsigned ALU_OP_W = ID_EX_ALU_OP_W,
    parameter int unsigned CNT_W    = ID_EX_CNT_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              flush,
    id_ex_pipe_stage_if.slave bus,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic                reg_write;
        logic [ALU_OP_W-1:0] alu_op;
        logic [DATA_W-1:0]   data1;
        logic [DATA_W-1:0]   data2;
        logic [RD_W-1:0]     rd;
    } payload_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    payload_t         in_pl, fill_pl;
    payload_t         main_q, main_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, main_free, fill_valid;

    assign in_pl = '{
        reg_write: bus.Reg_Write,
        alu_op:    bus.ALU_OP,
        data1:     bus.Data1,
        data2:     bus.Data2,
        rd:        bus.RD
    };

    // Main slot can take new contents when empty or being drained this cycle.
    assign main_free = !valid_q || bus.out_ready;

`ifdef ID_EX_SKID_EN
    logic     skid_valid;
    payload_t skid_pl;

    assign bus.in_ready = !skid_valid && !flush;
    assign accept       = bus.in_valid && bus.in_ready;
    // Skid entry is older than any concurrent input, so it refills main first.
    assign fill_valid   = skid_valid || accept;
    assign fill_pl      = skid_valid ? skid_pl : in_pl;

    id_ex_skid_buf #(
        .payload_t (payload_t)
    ) u_skid (
        .Clk     (Clk),
        .Reset   (Reset),
        .flush   (flush),
        .load_i  (accept && !main_free),
        .pop_i   (skid_valid && main_free),
        .data_i  (in_pl),
        .valid_o (skid_valid),
        .data_o  (skid_pl)
    );
`else
    assign bus.in_ready = !flush && main_free;
    assign accept       = bus.in_valid && bus.in_ready;
    assign fill_valid   = accept;
    assign fill_pl      = in_pl;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid_q <= 1'b0;
            main_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            main_q  <= main_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flush > refill > stall(hold) > drain to NOP; data fields survive flush and drain.
    always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d          = 1'b0;
            main_d.reg_write = 1'b0;
            main_d.alu_op    = '0;
        end else if (main_free) begin
            if (fill_valid) begin
                valid_d = 1'b1;
                main_d  = fill_pl;
            end else begin
                valid_d          = 1'b0;
                main_d.reg_write = 1'b0;
                main_d.alu_op    = '0;
            end
        end
        if (bus.out_ready && !valid_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign bus.out_valid       = valid_q;
    assign bus.ID_EX_Reg_Write = main_q.reg_write;
    assign bus.ID_EX_ALU_OP    = main_q.alu_op;
    assign bus.ID_EX_Data1     = main_q.data1;
    assign bus.ID_EX_Data2     = main_q.data2;
    assign bus.ID_EX_RD        = main_q.rd;
    assign bubble_cnt          = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Directed bench for id_ex_pipe_stage: reset, accept, stall, flush, drain and counter saturation.
module tb_id_ex_pipe_stage;
    import id_ex_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic             Clk;
    logic             Reset;
    logic             flush;
    logic [CNT_W-1:0] bubble_cnt;
    int unsigned      n_vec;
    int unsigned      n_err;

    id_ex_pipe_stage_if #(.DATA_W(8), .RD_W(3), .ALU_OP_W(1)) bus ();

    id_ex_pipe_stage #(
        .DATA_W   (8),
        .RD_W     (3),
        .ALU_OP_W (1),
        .CNT_W    (CNT_W)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .flush      (flush),
        .bus        (bus),
        .bubble_cnt (bubble_cnt)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic op,
                         input logic [7:0] d1, input logic [7:0] d2, input logic [2:0] rd);
        bus.in_valid  = v;
        bus.Reg_Write = rw;
        bus.ALU_OP    = op;
        bus.Data1     = d1;
        bus.Data2     = d2;
        bus.RD        = rd;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        Reset = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);

        // Power-on reset
        step();
        chk("por_valid", 32'(bus.out_valid), 32'd0);
        chk("por_data1", 32'(bus.ID_EX_Data1), 32'd0);
        chk("por_bub", 32'(bubble_cnt), 32'd0);
        #2 Reset = 1'b1;
        #1;
        chk("por_in_ready", 32'(bus.in_ready), 32'd1);

        // Idle run: counter climbs to 15 and saturates
        bus.out_ready = 1'b1;
        repeat (14) step();
        chk("bub_14", 32'(bubble_cnt), 32'd14);
        step();
        chk("bub_15", 32'(bubble_cnt), 32'd15);
        repeat (5) step();
        chk("bub_sat", 32'(bubble_cnt), 32'd15);

        // Asynchronous reset with a valid payload held
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 8'hA5, 8'h5A, 3'd6);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("pre_rst_data1", 32'(bus.ID_EX_Data1), 32'hA5);
        #1 Reset = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_data1", 32'(bus.ID_EX_Data1), 32'd0);
        chk("arst_rw", 32'(bus.ID_EX_Reg_Write), 32'd0);
        chk("arst_rd", 32'(bus.ID_EX_RD), 32'd0);
        chk("arst_bub", 32'(bubble_cnt), 32'd0);
        #2 Reset = 1'b1;

        // Back-to-back accepts
        drive(1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 3'd5);
        #1;
        chk("b2b_in_ready0", 32'(bus.in_ready), 32'd1);
        step();
        chk("b2b_a_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_a_rw", 32'(bus.ID_EX_Reg_Write), 32'd1);
        chk("b2b_a_op", 32'(bus.ID_EX_ALU_OP), 32'd1);
        chk("b2b_a_d1", 32'(bus.ID_EX_Data1), 32'h12);
        chk("b2b_a_d2", 32'(bus.ID_EX_Data2), 32'h34);
        chk("b2b_a_rd", 32'(bus.ID_EX_RD), 32'd5);
        drive(1'b1, 1'b0, 1'b0, 8'h56, 8'h78, 3'd2);
        bus.out_ready = 1'b1;
        #1;
        chk("b2b_in_ready1", 32'(bus.in_ready), 32'd1);
        step();
        chk("b2b_b_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_b_rw", 32'(bus.ID_EX_Reg_Write), 32'd0);
        chk("b2b_b_d1", 32'(bus.ID_EX_Data1), 32'h56);
        chk("b2b_b_d2", 32'(bus.ID_EX_Data2), 32'h78);
        chk("b2b_b_rd", 32'(bus.ID_EX_RD), 32'd2);
        chk("b2b_bub", 32'(bubble_cnt), 32'd0);

        // Drain with no new input leaves a NOP bubble, data held
        drive(1'b1, 1'b1, 1'b1, 8'h77, 8'h9A, 3'd1);
        step();
        chk("drn_load_d1", 32'(bus.ID_EX_Data1), 32'h77);
        chk("drn_load_rw", 32'(bus.ID_EX_Reg_Write), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
        step();
        chk("drn_valid", 32'(bus.out_valid), 32'd0);
        chk("drn_rw", 32'(bus.ID_EX_Reg_Write), 32'd0);
        chk("drn_op", 32'(bus.ID_EX_ALU_OP), 32'd0);
        chk("drn_d1", 32'(bus.ID_EX_Data1), 32'h77);
        chk("drn_bub", 32'(bubble_cnt), 32'd0);
        bus.out_ready = 1'b0;

        // Stall: outputs frozen, upstream blocked
        drive(1'b1, 1'b1, 1'b0, 8'h3C, 8'h11, 3'd4);
        step();
        chk("stl_valid", 32'(bus.out_valid), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 8'hC3, 8'h22, 3'd7);
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef ID_EX_SKID_EN
            chk("stl_in_ready", 32'(bus.in_ready), (i == 0) ? 32'd1 : 32'd0);
`else
            chk("stl_in_ready", 32'(bus.in_ready), 32'd0);
`endif
            step();
            chk("stl_d1", 32'(bus.ID_EX_Data1), 32'h3C);
            chk("stl_valid_hold", 32'(bus.out_valid), 32'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
        bus.out_ready = 1'b1;
        step();
`ifdef ID_EX_SKID_EN
        chk("skid_d1", 32'(bus.ID_EX_Data1), 32'hC3);
        chk("skid_valid", 32'(bus.out_valid), 32'd1);
        step();
        chk("stl_end_d1", 32'(bus.ID_EX_Data1), 32'hC3);
`else
        chk("stl_end_d1", 32'(bus.ID_EX_Data1), 32'h3C);
`endif
        chk("stl_end_valid", 32'(bus.out_valid), 32'd0);
        chk("stl_end_rw", 32'(bus.ID_EX_Reg_Write), 32'd0);
        chk("stl_end_bub", 32'(bubble_cnt), 32'd0);
        bus.out_ready = 1'b0;

        // Flush drops both the held entry and the concurrent input
        drive(1'b1, 1'b1, 1'b1, 8'h44, 8'h55, 3'd3);
        step();
        chk("fl_pre_valid", 32'(bus.out_valid), 32'd1);
        chk("fl_pre_rw", 32'(bus.ID_EX_Reg_Write), 32'd1);
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'hEE, 3'd7);
        #1;
        chk("fl_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("fl_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_rw", 32'(bus.ID_EX_Reg_Write), 32'd0);
        chk("fl_op", 32'(bus.ID_EX_ALU_OP), 32'd0);
        chk("fl_d1", 32'(bus.ID_EX_Data1), 32'h44);
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
        bus.out_ready = 1'b1;
        step();
        chk("fl_post_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_post_d1", 32'(bus.ID_EX_Data1), 32'h44);
        chk("fl_post_bub", 32'(bubble_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
